// File: rtl/execute_cond_stage_pkg.sv
// Shared encodings for condition codes, flag bit positions and the decode->execute control word.
package execute_cond_stage_pkg;

  localparam int unsigned COND_W       = 4;
  localparam int unsigned FLAG_W       = 4;
  localparam int unsigned ALU_CTRL_W   = 2;
  localparam int unsigned FLAG_WRITE_W = 2;

  typedef enum logic [COND_W-1:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  // Bit positions inside the {N,Z,C,V} flags word.
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // FlagWrite bits: NZ enables N,Z update; CV enables C,V update.
  localparam int unsigned FW_NZ = 1;
  localparam int unsigned FW_CV = 0;

  typedef struct packed {
    logic [COND_W-1:0]       cond;
    logic                    pc_src;
    logic                    reg_write;
    logic                    mem_to_reg;
    logic                    mem_write;
    logic                    branch;
    logic                    alu_src;
    logic                    no_write;
    logic [ALU_CTRL_W-1:0]   alu_control;
    logic [FLAG_WRITE_W-1:0] flag_write;
  } ctrl_t;

endpackage

// File: rtl/execute_cond_stage_cond_check.sv
// Combinational evaluation of an ARM condition field against the NZCV flags.
module cond_check
  import execute_cond_stage_pkg::*;
(
  input  logic [COND_W-1:0] cond,
  input  logic [FLAG_W-1:0] flags,
  output logic              cond_ex
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/execute_cond_stage.sv
// Decode->execute pipeline register, NZCV flags register and condition gating of state-changing controls.
module execute_cond_stage
  import execute_cond_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    FlushE,
  input  logic [COND_W-1:0]       CondD,
  input  logic                    PCSrcD,
  input  logic                    RegWriteD,
  input  logic                    MemtoRegD,
  input  logic                    MemWriteD,
  input  logic                    BranchD,
  input  logic                    ALUSrcD,
  input  logic                    NoWriteD,
  input  logic [ALU_CTRL_W-1:0]   ALUControlD,
  input  logic [FLAG_WRITE_W-1:0] FlagWriteD,
  input  logic [FLAG_W-1:0]       ALUFlags,
  output logic [ALU_CTRL_W-1:0]   ALUControlE,
  output logic                    ALUSrcE,
  output logic                    MemtoRegE,
  output logic                    CondExE,
  output logic                    PCSrcGE,
  output logic                    RegWriteGE,
  output logic                    MemWriteGE,
  output logic                    BranchTakenE,
  output logic [FLAG_W-1:0]       FlagsE
);

  ctrl_t            ctrl_d;
  ctrl_t            ctrl_e;
  logic [FLAG_W-1:0] flags;
  logic             cond_ex;

  assign ctrl_d = '{
    cond:        CondD,
    pc_src:      PCSrcD,
    reg_write:   RegWriteD,
    mem_to_reg:  MemtoRegD,
    mem_write:   MemWriteD,
    branch:      BranchD,
    alu_src:     ALUSrcD,
    no_write:    NoWriteD,
    alu_control: ALUControlD,
    flag_write:  FlagWriteD
  };

  // Execute register: a flush loads the all-zero bubble; there is no stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_e <= '0;
    end else if (FlushE) begin
      ctrl_e <= '0;
    end else begin
      ctrl_e <= ctrl_d;
    end
  end

  // Flags update for the instruction currently in execute, independent of FlushE.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags <= '0;
    end else begin
      if (ctrl_e.flag_write[FW_NZ] && cond_ex) begin
        flags[FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
      end
      if (ctrl_e.flag_write[FW_CV] && cond_ex) begin
        flags[FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
      end
    end
  end

  cond_check u_cond_check (
    .cond    (ctrl_e.cond),
    .flags   (flags),
    .cond_ex (cond_ex)
  );

  assign ALUControlE  = ctrl_e.alu_control;
  assign ALUSrcE      = ctrl_e.alu_src;
  assign MemtoRegE    = ctrl_e.mem_to_reg;
  assign CondExE      = cond_ex;
  assign PCSrcGE      = ctrl_e.pc_src & cond_ex;
  assign RegWriteGE   = ctrl_e.reg_write & cond_ex & ~ctrl_e.no_write;
  assign MemWriteGE   = ctrl_e.mem_write & cond_ex;
  assign BranchTakenE = ctrl_e.branch & cond_ex;
  assign FlagsE       = flags;

endmodule

// File: tb/tb_execute_cond_stage.sv
// Scoreboard bench for execute_cond_stage: driver updates a reference model and queues expectations, monitor compares.
module tb_execute_cond_stage;

  typedef struct packed {
    logic [3:0] cond;
    logic       pcsrc;
    logic       regwrite;
    logic       memtoreg;
    logic       memwrite;
    logic       branch;
    logic       alusrc;
    logic       nowrite;
    logic [1:0] aluc;
    logic [1:0] fw;
  } word_t;

  typedef struct packed {
    logic       cond_ex;
    logic [3:0] gated;
    logic [3:0] ungated;
    logic [3:0] flags;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       FlushE = 1'b0;
  logic [3:0] CondD = '0;
  logic       PCSrcD = 1'b0, RegWriteD = 1'b0, MemtoRegD = 1'b0, MemWriteD = 1'b0;
  logic       BranchD = 1'b0, ALUSrcD = 1'b0, NoWriteD = 1'b0;
  logic [1:0] ALUControlD = '0;
  logic [1:0] FlagWriteD = '0;
  logic [3:0] ALUFlags = '0;
  logic [1:0] ALUControlE;
  logic       ALUSrcE, MemtoRegE, CondExE, PCSrcGE, RegWriteGE, MemWriteGE, BranchTakenE;
  logic [3:0] FlagsE;

  execute_cond_stage dut (
    .clk          (clk),
    .reset        (reset),
    .FlushE       (FlushE),
    .CondD        (CondD),
    .PCSrcD       (PCSrcD),
    .RegWriteD    (RegWriteD),
    .MemtoRegD    (MemtoRegD),
    .MemWriteD    (MemWriteD),
    .BranchD      (BranchD),
    .ALUSrcD      (ALUSrcD),
    .NoWriteD     (NoWriteD),
    .ALUControlD  (ALUControlD),
    .FlagWriteD   (FlagWriteD),
    .ALUFlags     (ALUFlags),
    .ALUControlE  (ALUControlE),
    .ALUSrcE      (ALUSrcE),
    .MemtoRegE    (MemtoRegE),
    .CondExE      (CondExE),
    .PCSrcGE      (PCSrcGE),
    .RegWriteGE   (RegWriteGE),
    .MemWriteGE   (MemWriteGE),
    .BranchTakenE (BranchTakenE),
    .FlagsE       (FlagsE)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_pass   = 0;
  exp_t  q[$];
  word_t m_e = '0;
  logic [3:0] m_flags = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Condition rule: even/odd code pairs share a base test, odd codes invert it.
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy & !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (c == 4'd15) return 1'b0;
    if (c == 4'd14) return 1'b1;
    return base ^ c[0];
  endfunction

  function automatic word_t mk(input logic [3:0] cond, input logic pcsrc, input logic regwrite,
                               input logic memwrite, input logic branch, input logic nowrite,
                               input logic [1:0] fw);
    word_t w;
    w = word_t'($urandom);
    w.cond = cond; w.pcsrc = pcsrc; w.regwrite = regwrite; w.memwrite = memwrite;
    w.branch = branch; w.nowrite = nowrite; w.fw = fw;
    return w;
  endfunction

  // Apply one cycle of inputs, advance the reference model over the coming edge, queue the result.
  task automatic step(input logic rst, input logic flush, input word_t d, input logic [3:0] af);
    logic ce;
    exp_t e;
    @(negedge clk);
    reset = rst; FlushE = flush; ALUFlags = af;
    CondD = d.cond; PCSrcD = d.pcsrc; RegWriteD = d.regwrite; MemtoRegD = d.memtoreg;
    MemWriteD = d.memwrite; BranchD = d.branch; ALUSrcD = d.alusrc; NoWriteD = d.nowrite;
    ALUControlD = d.aluc; FlagWriteD = d.fw;
    if (rst) begin
      m_e = '0;
      m_flags = '0;
    end else begin
      ce = cond_pass(m_e.cond, m_flags);
      if (m_e.fw[1] && ce) m_flags[3:2] = af[3:2];
      if (m_e.fw[0] && ce) m_flags[1:0] = af[1:0];
      m_e = flush ? word_t'(0) : d;
    end
    ce = cond_pass(m_e.cond, m_flags);
    e.cond_ex = ce;
    e.gated   = {m_e.pcsrc & ce, m_e.regwrite & ce & !m_e.nowrite, m_e.memwrite & ce, m_e.branch & ce};
    e.ungated = {m_e.aluc, m_e.alusrc, m_e.memtoreg};
    e.flags   = m_flags;
    q.push_back(e);
  endtask

  // Monitor: compare DUT outputs against the oldest expectation shortly after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("cond_ex", 32'(CondExE), 32'(e.cond_ex));
        chk("gated", 32'({PCSrcGE, RegWriteGE, MemWriteGE, BranchTakenE}), 32'(e.gated));
        chk("ungated", 32'({ALUControlE, ALUSrcE, MemtoRegE}), 32'(e.ungated));
        chk("flags", 32'(FlagsE), 32'(e.flags));
      end
    end
  end

  initial begin
    // Reset held with random inputs, then first valid word.
    step(1'b1, 1'b0, word_t'($urandom), 4'($urandom));
    step(1'b1, 1'b0, word_t'($urandom), 4'($urandom));
    step(1'b0, 1'b0, mk(4'hE, 1, 1, 1, 1, 0, 2'b00), 4'h0);

    // SUBS setting Z, then BEQ taken; repeat with Z clear so BEQ falls through.
    step(1'b0, 1'b0, mk(4'hE, 0, 1, 0, 0, 0, 2'b11), 4'h0);
    step(1'b0, 1'b0, mk(4'h0, 1, 0, 0, 1, 0, 2'b00), 4'b0100);
    step(1'b0, 1'b0, mk(4'hE, 0, 1, 0, 0, 0, 2'b11), 4'h0);
    step(1'b0, 1'b0, mk(4'h0, 1, 0, 0, 1, 0, 2'b00), 4'b0000);

    // CMP: writes flags, never the register file.
    step(1'b0, 1'b0, mk(4'hE, 0, 1, 0, 0, 1, 2'b11), 4'h0);
    step(1'b0, 1'b0, mk(4'hE, 0, 0, 0, 0, 0, 2'b11), 4'b1001);

    // Partial write: flags to 1111, then NZ-only write of 0000.
    step(1'b0, 1'b0, mk(4'hE, 0, 0, 0, 0, 0, 2'b10), 4'b1111);
    step(1'b0, 1'b0, word_t'(0), 4'b0000);

    // Set Z, then STRNE with flag write and differing ALUFlags: suppressed entirely.
    step(1'b0, 1'b0, mk(4'hE, 0, 0, 0, 0, 0, 2'b11), 4'h0);
    step(1'b0, 1'b0, mk(4'h1, 0, 0, 1, 0, 0, 2'b11), 4'b0100);
    step(1'b0, 1'b0, word_t'(0), 4'b1011);

    // Flush while a flag-setting AL instruction is in execute.
    step(1'b0, 1'b0, mk(4'hE, 1, 1, 1, 1, 0, 2'b11), 4'h0);
    step(1'b0, 1'b1, mk(4'hE, 1, 1, 1, 1, 0, 2'b11), 4'b1010);
    step(1'b0, 1'b0, word_t'(0), 4'h0);

    // Reset and flush together.
    step(1'b1, 1'b1, word_t'($urandom), 4'($urandom));

    // Sweep every condition against every flags value.
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        step(1'b0, 1'b0, mk(4'hE, 0, 0, 0, 0, 0, 2'b11), 4'($urandom));
        step(1'b0, 1'b0, mk(4'(c), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                            1'($urandom), 2'b00), 4'(f));
      end
    end

    // Random traffic with occasional flushes and resets.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0), word_t'($urandom), 4'($urandom));
    end

    step(1'b0, 1'b0, word_t'(0), 4'h0);
    repeat (3) @(posedge clk);
    #2;
    chk("drain", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/execute_cond_stage.md
# execute_cond_stage

Decode-to-execute boundary of the pipelined ARM core. Registers the decoded control word produced in the decode stage into the execute stage and holds the NZCV flags register. Evaluates the instruction's condition field against the flags and gates every state-changing control signal before it leaves execute. Its outputs drive the execute datapath (ALU, source mux), the PC-select logic, and the execute/memory pipeline register.

## Interface
Parameters: none (all widths fixed by the ISA).

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- FlushE  in  1  load a bubble into execute at the next edge (hazard unit).
- CondD  in  4  condition field, Instr[31:28].
- PCSrcD, RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD, NoWriteD  in  1 each  decoded controls.
- ALUControlD  in  2  ALU operation.
- FlagWriteD  in  2  bit1 enables N,Z update; bit0 enables C,V update.
- ALUFlags  in  4  {N,Z,C,V} from the execute-stage ALU, combinational, same cycle.
- ALUControlE  out  2  registered ALU operation.
- ALUSrcE, MemtoRegE  out  1 each  registered, ungated.
- CondExE  out  1  condition passed for the instruction in execute.
- PCSrcGE, RegWriteGE, MemWriteGE  out  1 each  gated controls.
- BranchTakenE  out  1  BranchE & CondExE.
- FlagsE  out  4  current flags register {N,Z,C,V}.

## Operation
- Execute register holds all D-side inputs except ALUFlags. Each edge: reset → all fields 0; else FlushE → all fields 0 (bubble); else capture D inputs. No stall input: execute never holds.
- Condition check (combinational on CondE, FlagsE): EQ 0000 Z; NE 0001 !Z; CS 0010 C; CC 0011 !C; MI 0100 N; PL 0101 !N; VS 0110 V; VC 0111 !V; HI 1000 C&!Z; LS 1001 !C|Z; GE 1010 N==V; LT 1011 N!=V; GT 1100 !Z&(N==V); LE 1101 Z|(N!=V); AL 1110 1; 1111 → 0 (never).
- Gating: PCSrcGE = PCSrcE & CondExE; RegWriteGE = RegWriteE & CondExE & !NoWriteE; MemWriteGE = MemWriteE & CondExE; BranchTakenE = BranchE & CondExE.
- Flags register: at each edge, if reset, FlagsE ← 0. Otherwise, if FlagWriteE[1] & CondExE, update [3:2] from ALUFlags[3:2]. If FlagWriteE[0] & CondExE, update [1:0] from ALUFlags[1:0]. Fields not enabled hold their value.
- The condition is always evaluated against the registered flags. The same instruction's ALUFlags never affect its own CondExE.

## Timing
- Latency: D inputs visible on E outputs 1 cycle after capture. Gated outputs are combinational from E register and FlagsE in the same cycle.
- Flag forwarding: a flag-setting instruction in cycle n updates FlagsE at end of n. A conditional instruction entering E in n+1 sees the new value; no bubble is required.
- FlushE does not suppress the flags update of the instruction currently in execute. Flush affects only what enters execute.
- After reset: every output 0, including CondExE, because CondE = 0000 (EQ) and Z = 0. A bubble (all-zero word) produces no gated activity regardless of CondExE.
- Reset and FlushE asserted together: reset wins; the result is identical except that FlagsE also clears.
- Reset mid-operation discards the instruction in execute and the flags. The first valid instruction follows on the edge after reset deasserts.

## Structure
- Shared package: the 4-bit condition-code constants (EQ…AL, NV), flag bit indices (N=3, Z=2, C=1, V=0), and the FlagWrite bit meanings. The decoder and the hazard unit also use these.
- One sub-module, cond_check: pure combinational condition evaluation (CondE, FlagsE → CondExE).
- The pipeline register and the flags register stay in this block.

## Test plan
- Reset held 2 cycles with random D inputs → all outputs 0 and FlagsE = 0000; first valid word appears 1 cycle after release.
- SUBS (FlagWriteD = 11, CondD = AL) with ALUFlags = 0100, then BEQ (BranchD = 1, PCSrcD = 1, CondD = EQ) next cycle → FlagsE = 0100, BranchTakenE = 1, PCSrcGE = 1. With ALUFlags = 0000 instead, BranchTakenE = 0.
- CMP (RegWriteD = 1, NoWriteD = 1, FlagWriteD = 11, AL) → RegWriteGE = 0 and flags updated.
- Partial write: FlagsE = 1111, then FlagWriteE = 10 with ALUFlags = 0000 → FlagsE = 0011.
- Conditional STRNE with Z = 1 → MemWriteGE = 0 and FlagsE unchanged, even when FlagWriteE = 11 with differing ALUFlags.
- FlushE asserted while a flag-setting AL instruction is in execute → flags update that edge; the next cycle's E outputs are all 0.
- Sweep all 16 CondD values against all 16 FlagsE values → CondExE matches the condition table, with NV always 0.
